dif_readout_arbiter: RTL and testbench
======================================

Name: dif_readout_arbiter

Overview:
Packet-level round-robin arbiter that shares the single external USB FIFO write port between NUM_SRC ASIC readout streams on the DIF.
- Each source is, for example, a per-ASIC RAM-readout path already buffered by a small upstream FIFO.
- Each granted packet is framed with a header word (tag + source index) and a trailer word (data-word count).
- The block sits between the per-ASIC readout/DAQ logic and the external FIFO interface, replacing direct MicrorocData-to-ExternalFifoData wiring.

Parameters:
- NUM_SRC, 4, number of requesting streams (2..16)
- HEADER_TAG, 8'hA5, upper byte of header word
- IDX_W, $clog2(NUM_SRC), width of source index

Ports:
- Clk  in  1  system clock (40 MHz domain)
- reset_n  in  1  reset; synchronous, active-low
- Enable  in  1  permit new grants
- SrcData  in  16*NUM_SRC  source words, source i at bits [16i+15:16i]
- SrcValid  in  NUM_SRC  source word valid
- SrcLast  in  NUM_SRC  qualifies final word of a packet
- SrcReady  out  NUM_SRC  word accepted when SrcValid & SrcReady
- ExternalFifoFull  in  1  almost-full from external FIFO, at least 2 words margin
- ExternalFifoData  out  16  registered write data
- ExternalFifoDataEnable  out  1  registered write strobe
- Busy  out  1  high in any state other than IDLE
- GrantIndex  out  IDX_W  currently or last granted source
- PacketCount  out  16  completed packets, wraps at 16'hFFFF -> 0

Behaviour:
- Reset (reset_n low at a Clk edge):
  - State = IDLE.
  - All outputs 0, including SrcReady = 0.
  - RR pointer = NUM_SRC-1, so source 0 wins first.
  - Word counter and PacketCount = 0.
- States: IDLE -> HEADER -> DATA -> TRAILER -> IDLE.
- IDLE:
  - Condition: Enable & |SrcValid.
  - Grant the first valid source searching from pointer+1 upward, wrapping modulo NUM_SRC.
  - Register the grant into GrantIndex, clear the word counter, go to HEADER. This costs 1 cycle.
- HEADER:
  - If !ExternalFifoFull: write {HEADER_TAG, zero-extended GrantIndex} and go to DATA.
  - Otherwise stall.
- DATA:
  - SrcReady[g] = !ExternalFifoFull, combinational. All other SrcReady bits stay 0.
  - On a handshake: next cycle ExternalFifoDataEnable=1 with the accepted word. Latency is exactly 1 cycle.
  - The word counter increments on each handshake and saturates at 16'hFFFF.
  - A handshake with SrcLast[g] set goes to TRAILER.
  - SrcValid low causes a bubble only. The grant is held; no timeout.
- TRAILER:
  - If !ExternalFifoFull: write the word count (data words only).
  - Set pointer = GrantIndex and increment PacketCount.
  - Go to IDLE.
- ExternalFifoDataEnable:
  - Asserts only for a header, data or trailer write in the preceding cycle.
  - Otherwise 0, with ExternalFifoData holding its last value.
- Full handling:
  - ExternalFifoFull is sampled in the same cycle the write decision is made.
  - The 2-word margin absorbs the registered-output latency.
  - No write is ever issued in a cycle that follows Full=1 being sampled.
- Enable:
  - Deasserting Enable mid-packet does not abort; the packet completes through TRAILER.
  - No new grant is made while Enable=0.
- Other rules:
  - SrcLast without SrcValid is ignored.
  - Simultaneous requests are resolved strictly by RR order. A source requesting continuously cannot win twice in a row while another source is valid in IDLE.
  - Reset mid-packet: immediate return to the reset state with no trailer emitted. The partial packet is lost, and the upstream buffer is flushed by the same reset.
  - Minimum packet length is 1 data word. Total framed length = N+2 words.

Decomposition:
- Shared package dif_readout_pkg:
  - state enum (IDLE, HEADER, DATA, TRAILER)
  - HEADER_TAG default
  - helper function for the round-robin search
- One natural sub-module: rr_priority_picker.
  - Combinational.
  - Inputs: request vector, pointer. Outputs: grant index, grant valid.
  - Reusable by a future trigger/hold scheduler.

Test Plan:
1. Single source 1 with 3 words (0x1111, 0x2222, 0x3333 last), Full=0:
   - Output sequence 0xA501, 0x1111, 0x2222, 0x3333, 0x0003.
   - One strobe per word, each 1 cycle after its handshake.
   - PacketCount = 1.
2. All four sources valid continuously, 1-word packets, 8 packets:
   - Header order 0xA500, 0xA501, 0xA502, 0xA503, 0xA500, ...
   - No source is granted twice consecutively.
3. ExternalFifoFull toggled high for 5 cycles in mid-DATA:
   - SrcReady[g] is 0 for exactly those cycles.
   - No strobe in the cycle after any Full=1 sample.
   - No words are lost or duplicated.
4. Enable dropped during word 2 of a 4-word packet:
   - The packet completes with trailer 0x0004.
   - Busy falls afterward, and no further header appears while Enable=0 even with SrcValid high.
5. reset_n pulsed low during DATA after 2 words:
   - Next cycle all outputs are 0 and state is IDLE.
   - No trailer is emitted.
   - The next grant goes to source 0 even if source 3 requested first.
6. Source 2 with 70000 words:
   - Trailer = 0xFFFF (saturated).
   - PacketCount increments by 1.

Source files
------------

// File: rtl/dif_readout_pkg.sv
// Shared definitions for the DIF readout arbiter.
//   arbState_e         : packet framing FSM states
//   DEFAULT_HEADER_TAG : upper byte of every header word
//   MAX_SRC            : largest supported number of sources
//   rrSearch()         : round-robin search helper shared by pickers
package dif_readout_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        DATA    = 2'd2,
        TRAILER = 2'd3
    } arbState_e;

    localparam logic [7:0] DEFAULT_HEADER_TAG = 8'hA5;
    localparam int         MAX_SRC            = 16;

    // Returns the first set request found searching upward from ptr+1,
    // wrapping modulo numSrc, or -1 when nothing is requesting.
    function automatic int rrSearch(input logic [MAX_SRC-1:0] req,
                                    input int                 ptr,
                                    input int                 numSrc);
        int idx;
        int found;
        found = -1;
        for (int k = 1; k <= MAX_SRC; k++) begin
            idx = ptr + k;
            if (idx >= numSrc) begin
                idx = idx - numSrc;
            end
            if (k <= numSrc && found < 0 && req[idx[3:0]]) begin
                found = idx;
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/dif_readout_arbiter_if.sv
// Bus bundle between the per-ASIC readout streams, the arbiter and the
// external USB FIFO write port.
//   SrcData/SrcValid/SrcLast : packed source streams, source i at [16i+15:16i]
//   SrcReady                 : per-source accept
//   ExternalFifoFull         : almost-full from the external FIFO
//   ExternalFifoData/Enable  : registered write port
// master = arbiter side, slave = sources + FIFO side.
interface dif_readout_arbiter_if #(
    parameter int NUM_SRC = 4
);
    logic [16*NUM_SRC-1:0] SrcData;
    logic [NUM_SRC-1:0]    SrcValid;
    logic [NUM_SRC-1:0]    SrcLast;
    logic [NUM_SRC-1:0]    SrcReady;
    logic                  ExternalFifoFull;
    logic [15:0]           ExternalFifoData;
    logic                  ExternalFifoDataEnable;

    modport master (
        input  SrcData, SrcValid, SrcLast, ExternalFifoFull,
        output SrcReady, ExternalFifoData, ExternalFifoDataEnable
    );

    modport slave (
        output SrcData, SrcValid, SrcLast, ExternalFifoFull,
        input  SrcReady, ExternalFifoData, ExternalFifoDataEnable
    );
endinterface

// File: rtl/dif_readout_arbiter_rr_priority_picker.sv
// Combinational round-robin picker.
//   request    : one request bit per source
//   pointer    : last winner; search starts at pointer+1
//   grantIndex : winning source (0 when none)
//   grantValid : at least one request present
module rr_priority_picker
    import dif_readout_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] request,
    input  logic [IDX_W-1:0]   pointer,
    output logic [IDX_W-1:0]   grantIndex,
    output logic               grantValid
);

    logic [MAX_SRC-1:0] reqExt;
    int                 sel;

    always_comb begin
        reqExt              = '0;
        reqExt[NUM_SRC-1:0] = request;
        sel                 = rrSearch(reqExt, int'(pointer), NUM_SRC);
        grantValid          = (sel >= 0);
        grantIndex          = grantValid ? sel[IDX_W-1:0] : '0;
    end

endmodule

// File: rtl/dif_readout_arbiter.sv
// Packet-level round-robin arbiter sharing the external USB FIFO write
// port between NUM_SRC readout streams. Each granted packet is framed as
// header {HEADER_TAG, source index}, data words, trailer (data-word count).
//   Clk, reset_n : clock, synchronous active-low reset
//   Enable       : permits new grants (an open packet always completes)
//   bus          : source streams + external FIFO port (master side)
//   Busy         : FSM outside IDLE
//   GrantIndex   : current or last granted source
//   PacketCount  : completed packets, wrapping
module dif_readout_arbiter
    import dif_readout_pkg::*;
#(
    parameter int         NUM_SRC    = 4,
    parameter logic [7:0] HEADER_TAG = DEFAULT_HEADER_TAG,
    parameter int         IDX_W      = $clog2(NUM_SRC)
) (
    input  logic                  Clk,
    input  logic                  reset_n,
    input  logic                  Enable,
    dif_readout_arbiter_if.master bus,
    output logic                  Busy,
    output logic [IDX_W-1:0]      GrantIndex,
    output logic [15:0]           PacketCount
);

    arbState_e          stateReg, stateNext;
    logic [IDX_W-1:0]   grantReg, grantNext;
    logic [IDX_W-1:0]   ptrReg, ptrNext;
    logic [15:0]        wordCntReg, wordCntNext;
    logic [15:0]        pktCntReg, pktCntNext;
    logic [15:0]        dataReg, dataNext;
    logic               enReg, enNext;
    logic [NUM_SRC-1:0] readyVec;

    logic [IDX_W-1:0]   pickIndex;
    logic               pickValid;
    logic [15:0]        srcWord [NUM_SRC];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : gUnpack
            assign srcWord[gi] = bus.SrcData[16*gi +: 16];
        end
    endgenerate

    rr_priority_picker #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) uPicker (
        .request    (bus.SrcValid),
        .pointer    (ptrReg),
        .grantIndex (pickIndex),
        .grantValid (pickValid)
    );

    // Full is looked at in the same cycle every write is decided; the
    // FIFO's 2-word margin covers the registered output stage.
    always_comb begin
        stateNext   = stateReg;
        grantNext   = grantReg;
        ptrNext     = ptrReg;
        wordCntNext = wordCntReg;
        pktCntNext  = pktCntReg;
        dataNext    = dataReg;
        enNext      = 1'b0;
        readyVec    = '0;
        case (stateReg)
            IDLE: begin
                if (Enable && pickValid) begin
                    grantNext   = pickIndex;
                    wordCntNext = '0;
                    stateNext   = HEADER;
                end
            end
            HEADER: begin
                if (!bus.ExternalFifoFull) begin
                    dataNext  = {HEADER_TAG, {(8-IDX_W){1'b0}}, grantReg};
                    enNext    = 1'b1;
                    stateNext = DATA;
                end
            end
            DATA: begin
                readyVec[grantReg] = !bus.ExternalFifoFull;
                if (!bus.ExternalFifoFull && bus.SrcValid[grantReg]) begin
                    dataNext = srcWord[grantReg];
                    enNext   = 1'b1;
                    if (wordCntReg != 16'hFFFF) begin
                        wordCntNext = wordCntReg + 16'd1;
                    end
                    if (bus.SrcLast[grantReg]) begin
                        stateNext = TRAILER;
                    end
                end
            end
            TRAILER: begin
                if (!bus.ExternalFifoFull) begin
                    dataNext   = wordCntReg;
                    enNext     = 1'b1;
                    ptrNext    = grantReg;
                    pktCntNext = pktCntReg + 16'd1;
                    stateNext  = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Pointer resets to the last source so source 0 wins the first grant.
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            stateReg   <= IDLE;
            grantReg   <= '0;
            ptrReg     <= IDX_W'(NUM_SRC - 1);
            wordCntReg <= '0;
            pktCntReg  <= '0;
            dataReg    <= '0;
            enReg      <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            grantReg   <= grantNext;
            ptrReg     <= ptrNext;
            wordCntReg <= wordCntNext;
            pktCntReg  <= pktCntNext;
            dataReg    <= dataNext;
            enReg      <= enNext;
        end
    end

    assign bus.SrcReady               = readyVec;
    assign bus.ExternalFifoData       = dataReg;
    assign bus.ExternalFifoDataEnable = enReg;
    assign Busy                       = (stateReg != IDLE);
    assign GrantIndex                 = grantReg;
    assign PacketCount                = pktCntReg;

endmodule

// File: tb/tb_dif_readout_arbiter.sv
// Directed bench for dif_readout_arbiter with four sources. Sources are
// modelled as per-source word generators; expected FIFO words are queued
// when a packet is offered and compared as each strobe appears.
module tb_dif_readout_arbiter;

    localparam int NS = 4;

    logic        Clk;
    logic        reset_n;
    logic        Enable;
    logic        Busy;
    logic [1:0]  GrantIndex;
    logic [15:0] PacketCount;

    dif_readout_arbiter_if #(.NUM_SRC(NS)) bus ();

    dif_readout_arbiter #(
        .NUM_SRC    (NS),
        .HEADER_TAG (8'hA5)
    ) dut (
        .Clk         (Clk),
        .reset_n     (reset_n),
        .Enable      (Enable),
        .bus         (bus),
        .Busy        (Busy),
        .GrantIndex  (GrantIndex),
        .PacketCount (PacketCount)
    );

    int          checks = 0;
    int          errors = 0;
    int          strobeCount = 0;
    logic [15:0] expQ [$];

    int          wordsLeft [NS];
    int          pktsLeft  [NS];
    int          pktLen    [NS];
    logic [15:0] cur       [NS];
    logic [15:0] inc       [NS];

    task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : srcAndMon
        logic [NS-1:0]    hsVec;
        logic [NS-1:0]    vVec;
        logic [NS-1:0]    lVec;
        logic [16*NS-1:0] dVec;
        logic             preFull;
        logic             preRst;
        logic [15:0]      expWord;
        for (int i = 0; i < NS; i++) begin
            wordsLeft[i] = 0; pktsLeft[i] = 0; pktLen[i] = 0;
            cur[i] = '0; inc[i] = '0;
        end
        bus.SrcData = '0; bus.SrcValid = '0; bus.SrcLast = '0;
        forever begin
            @(negedge Clk);
            for (int i = 0; i < NS; i++) begin
                dVec[i*16 +: 16] = cur[i];
                vVec[i]          = (wordsLeft[i] > 0);
                lVec[i]          = (wordsLeft[i] <= 1);
            end
            bus.SrcData  = dVec;
            bus.SrcValid = vVec;
            bus.SrcLast  = lVec;
            #4;
            preFull = bus.ExternalFifoFull;
            preRst  = reset_n;
            hsVec   = bus.SrcValid & bus.SrcReady;
            @(posedge Clk);
            #1;
            if (!preRst) begin
                for (int i = 0; i < NS; i++) begin
                    wordsLeft[i] = 0; pktsLeft[i] = 0;
                end
            end else begin
                if (preFull) begin
                    checks++;
                    if (bus.ExternalFifoDataEnable !== 1'b0)
                        fail("no_strobe_after_full", bus.ExternalFifoDataEnable, 1'b0);
                end
                if (hsVec != '0) begin
                    checks++;
                    if (bus.ExternalFifoDataEnable !== 1'b1)
                        fail("strobe_latency", bus.ExternalFifoDataEnable, 1'b1);
                end
                if (bus.ExternalFifoDataEnable === 1'b1) begin
                    strobeCount++;
                    checks++;
                    if (expQ.size() == 0)
                        fail("strobe_expected", 0, 1);
                    if (expQ.size() != 0) begin
                        expWord = expQ.pop_front();
                        $display("strobe %0d data=%04h expected=%04h", strobeCount, bus.ExternalFifoData, expWord);
                        checks++;
                        if (bus.ExternalFifoData !== expWord)
                            fail("fifo_data", bus.ExternalFifoData, expWord);
                    end
                end
                for (int i = 0; i < NS; i++) begin
                    if (hsVec[i]) begin
                        cur[i] = cur[i] + inc[i];
                        wordsLeft[i]--;
                        if (wordsLeft[i] == 0 && pktsLeft[i] > 0) begin
                            pktsLeft[i]--;
                            wordsLeft[i] = pktLen[i];
                        end
                    end
                end
            end
        end
    end

    task automatic setSrc(input int s, input int len, input int pkts,
                          input logic [15:0] base, input logic [15:0] step);
        pktLen[s]    = len;
        pktsLeft[s]  = pkts - 1;
        cur[s]       = base;
        inc[s]       = step;
        wordsLeft[s] = len;
    endtask

    task automatic pushPkt(input int s, input int len,
                           input logic [15:0] base, input logic [15:0] step);
        logic [15:0] w;
        w = base;
        expQ.push_back(16'hA500 | 16'(s));
        for (int k = 0; k < len; k++) begin
            expQ.push_back(w);
            w = w + step;
        end
        expQ.push_back((len >= 65535) ? 16'hFFFF : 16'(len));
    endtask

    task automatic waitStrobes(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (strobeCount < n && c < budget) begin
            @(negedge Clk);
            c++;
        end
        checks++;
        if (strobeCount < n) fail(tag, strobeCount, n);
    endtask

    task automatic waitIdle(input int budget, input string tag);
        int c;
        c = 0;
        while (!(expQ.size() == 0 && Busy === 1'b0) && c < budget) begin
            @(negedge Clk);
            c++;
        end
        checks++;
        if (expQ.size() != 0) fail(tag, expQ.size(), 0);
    endtask

    task automatic checkResetState(input string tag);
        $display("%s: reset state check", tag);
        checks++;
        if (bus.ExternalFifoData !== 16'h0000) fail("rst_data", bus.ExternalFifoData, 16'h0000);
        checks++;
        if (bus.ExternalFifoDataEnable !== 1'b0) fail("rst_strobe", bus.ExternalFifoDataEnable, 1'b0);
        checks++;
        if (Busy !== 1'b0) fail("rst_busy", Busy, 1'b0);
        checks++;
        if (GrantIndex !== 2'd0) fail("rst_grant", GrantIndex, 2'd0);
        checks++;
        if (PacketCount !== 16'd0) fail("rst_pktcnt", PacketCount, 16'd0);
        checks++;
        if (bus.SrcReady !== 4'h0) fail("rst_ready", bus.SrcReady, 4'h0);
    endtask

    initial begin : mainSeq
        int sc;
        reset_n = 1'b0;
        Enable  = 1'b0;
        bus.ExternalFifoFull = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checkResetState("reset");
        @(negedge Clk);
        reset_n = 1'b1;

        for (int s = 0; s < NS; s++) setSrc(s, 1, 2, 16'(256 * (s + 1)), 16'h0001);
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < NS; s++) pushPkt(s, 1, 16'(256 * (s + 1) + r), 16'h0001);
        Enable = 1'b1;
        waitIdle(300, "t2_drain");
        checks++;
        if (PacketCount !== 16'd8) fail("t2_pktcnt", PacketCount, 16'd8);

        @(negedge Clk);
        setSrc(1, 3, 1, 16'h1111, 16'h1111);
        pushPkt(1, 3, 16'h1111, 16'h1111);
        waitIdle(100, "t1_drain");
        checks++;
        if (PacketCount !== 16'd9) fail("t1_pktcnt", PacketCount, 16'd9);

        @(negedge Clk);
        sc = strobeCount;
        setSrc(3, 8, 1, 16'h3000, 16'h0011);
        pushPkt(3, 8, 16'h3000, 16'h0011);
        waitStrobes(sc + 4, 100, "t3_reach_data");
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge Clk);
            bus.ExternalFifoFull = 1'b1;
            #1;
            checks++;
            if (bus.SrcReady !== 4'h0) fail("t3_ready_low", bus.SrcReady, 4'h0);
        end
        @(negedge Clk);
        bus.ExternalFifoFull = 1'b0;
        #1;
        checks++;
        if (bus.SrcReady !== 4'b1000) fail("t3_ready_back", bus.SrcReady, 4'b1000);
        waitIdle(100, "t3_drain");
        checks++;
        if (PacketCount !== 16'd10) fail("t3_pktcnt", PacketCount, 16'd10);

        @(negedge Clk);
        sc = strobeCount;
        setSrc(2, 4, 1, 16'h4000, 16'h0001);
        pushPkt(2, 4, 16'h4000, 16'h0001);
        waitStrobes(sc + 2, 100, "t4_reach_word2");
        Enable = 1'b0;
        setSrc(0, 1, 1, 16'h0AAA, 16'h0001);
        waitIdle(100, "t4_drain");
        checks++;
        if (PacketCount !== 16'd11) fail("t4_pktcnt", PacketCount, 16'd11);
        sc = strobeCount;
        repeat (20) @(negedge Clk);
        checks++;
        if (Busy !== 1'b0) fail("t4_busy_low", Busy, 1'b0);
        checks++;
        if (strobeCount != sc) fail("t4_no_new_strobe", strobeCount, sc);

        wordsLeft[0] = 0;
        pktsLeft[0]  = 0;
        repeat (2) @(negedge Clk);
        sc = strobeCount;
        setSrc(1, 6, 1, 16'h5000, 16'h0001);
        expQ.push_back(16'hA501);
        expQ.push_back(16'h5000);
        expQ.push_back(16'h5001);
        Enable = 1'b1;
        waitStrobes(sc + 3, 100, "t5_reach_word2");
        reset_n = 1'b0;
        @(posedge Clk);
        #1;
        checkResetState("t5_reset");
        checks++;
        if (expQ.size() != 0) fail("t5_no_trailer_pending", expQ.size(), 0);
        @(negedge Clk);
        Enable = 1'b0;
        @(negedge Clk);
        reset_n = 1'b1;
        setSrc(3, 1, 1, 16'h7300, 16'h0001);
        repeat (2) @(negedge Clk);
        setSrc(0, 1, 1, 16'h7000, 16'h0001);
        pushPkt(0, 1, 16'h7000, 16'h0001);
        pushPkt(3, 1, 16'h7300, 16'h0001);
        repeat (2) @(negedge Clk);
        Enable = 1'b1;
        waitIdle(100, "t5_drain");
        checks++;
        if (PacketCount !== 16'd2) fail("t5_pktcnt", PacketCount, 16'd2);

        @(negedge Clk);
        setSrc(2, 70000, 1, 16'h0000, 16'h0001);
        pushPkt(2, 70000, 16'h0000, 16'h0001);
        waitIdle(71000, "t6_drain");
        checks++;
        if (PacketCount !== 16'd3) fail("t6_pktcnt", PacketCount, 16'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
